// File: rtl/pixel_mixer.sv
// Pixel mixer: pops background/sprite FIFO heads once per T-cycle, drops the SCX fine-scroll
// pixels, resolves priority, maps through the palettes and emits a registered shade and X.
module pixel_mixer #(
    parameter int unsigned X_MAX = 160
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       tclk_in,
    input  logic                       line_start_in,
    input  logic [7:0]                 SCX_in,
    input  logic                       bg_ena_in,
    input  logic                       sprite_ena_in,
    input  logic [7:0]                 BGP_in,
    input  logic [7:0]                 OBP0_in,
    input  logic [7:0]                 OBP1_in,
    input  logic [1:0]                 bg_pixel_in,
    input  logic                       bg_valid_in,
    output logic                       bg_rd_out,
    input  logic [1:0]                 sprite_pixel_in,
    input  logic                       sprite_valid_in,
    input  logic                       sprite_palette_in,
    input  logic                       sprite_priority_in,
    input  logic                       sprite_stall_in,
    output logic                       sprite_rd_out,
    output logic [1:0]                 shade_out,
    output logic [$clog2(X_MAX)-1:0]   X_out,
    output logic                       pixel_valid_out,
    output logic                       line_done_out
);

    localparam int unsigned XW = $clog2(X_MAX);
    localparam logic [XW-1:0] XLast = XW'(X_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDiscard,
        StDraw,
        StDone
    } state_t;

    state_t          state_q;
    logic [2:0]      disc_q;
    logic [XW-1:0]   x_q;

    logic            active;
    logic            pop;
    logic [1:0]      bg_idx;
    logic            sprite_win;
    logic [1:0]      win_idx;
    logic [7:0]      win_pal;
    logic [1:0]      shade_d;

    // Only the fine-scroll bits matter; the coarse part is handled by the fetcher.
    logic            unused_scx;
    assign unused_scx = ^SCX_in[7:3];

    assign active = (state_q == StDiscard) || (state_q == StDraw);

    // A line start takes the cycle for itself, so nothing is popped alongside it.
    assign pop = tclk_in && bg_valid_in && !sprite_stall_in && active && !line_start_in;

    assign bg_rd_out     = pop;
    assign sprite_rd_out = pop && sprite_valid_in && (state_q == StDraw);

    assign bg_idx     = bg_ena_in ? bg_pixel_in : 2'd0;
    assign sprite_win = sprite_ena_in && sprite_valid_in && (sprite_pixel_in != 2'd0) &&
                        (!sprite_priority_in || (bg_idx == 2'd0));

    always_comb begin
        win_idx = bg_idx;
        win_pal = BGP_in;
        if (sprite_win) begin
            win_idx = sprite_pixel_in;
            win_pal = sprite_palette_in ? OBP1_in : OBP0_in;
        end
        shade_d = win_pal[{win_idx, 1'b0} +: 2];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= StIdle;
            disc_q          <= 3'd0;
            x_q             <= '0;
            shade_out       <= 2'd0;
            X_out           <= '0;
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
        end else begin
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
            if (line_start_in) begin
                disc_q  <= SCX_in[2:0];
                x_q     <= '0;
                state_q <= (SCX_in[2:0] != 3'd0) ? StDiscard : StDraw;
            end else begin
                unique case (state_q)
                    StDiscard: begin
                        if (pop) begin
                            disc_q <= disc_q - 3'd1;
                            if (disc_q == 3'd1) begin
                                state_q <= StDraw;
                            end
                        end
                    end
                    StDraw: begin
                        if (pop) begin
                            shade_out       <= shade_d;
                            X_out           <= x_q;
                            pixel_valid_out <= 1'b1;
                            x_q             <= x_q + XW'(1);
                            if (x_q == XLast) begin
                                line_done_out <= 1'b1;
                                state_q       <= StDone;
                            end
                        end
                    end
                    StIdle, StDone: begin
                        state_q <= state_q;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Scoreboard bench for pixel_mixer: expected pixels are queued at pop time and compared
// when pixel_valid_out appears.
module tb_pixel_mixer;

    localparam int X_MAX = 160;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tclk, line_start, bg_ena, sprite_ena;
    logic [7:0] scx, bgp, obp0, obp1;
    logic [1:0] bg_pixel, sprite_pixel;
    logic       bg_valid, sprite_valid, sprite_palette, sprite_priority, sprite_stall;
    logic       bg_rd, sprite_rd;
    logic [1:0] shade;
    logic [7:0] x_out;
    logic       pixel_valid, line_done;

    int n_vec = 0;
    int n_err = 0;
    int pix_cnt = 0;
    int last_x = -1;

    // Bench model: 0 idle, 1 discard, 2 draw, 3 done.
    int m_state = 0;
    int m_disc = 0;
    int m_x = 0;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    pixel_mixer #(.X_MAX(X_MAX)) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .tclk_in           (tclk),
        .line_start_in     (line_start),
        .SCX_in            (scx),
        .bg_ena_in         (bg_ena),
        .sprite_ena_in     (sprite_ena),
        .BGP_in            (bgp),
        .OBP0_in           (obp0),
        .OBP1_in           (obp1),
        .bg_pixel_in       (bg_pixel),
        .bg_valid_in       (bg_valid),
        .bg_rd_out         (bg_rd),
        .sprite_pixel_in   (sprite_pixel),
        .sprite_valid_in   (sprite_valid),
        .sprite_palette_in (sprite_palette),
        .sprite_priority_in(sprite_priority),
        .sprite_stall_in   (sprite_stall),
        .sprite_rd_out     (sprite_rd),
        .shade_out         (shade),
        .X_out             (x_out),
        .pixel_valid_out   (pixel_valid),
        .line_done_out     (line_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (pixel_valid === 1'b1) begin
            pix_cnt++;
            last_x = int'(x_out);
            if (sb.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                e = sb.pop_front();
                check("shade", shade, e[1:0]);
                check("x_out", x_out, e[9:2]);
                check("line_done", line_done, e[10]);
            end
        end else if (line_done !== 1'b0) begin
            check("stray_line_done", line_done, 0);
        end
    end

    // One T-cycle followed by one non-T clock; ovr >= 0 forces the expected shade.
    task automatic t_cycle(input bit bgv, input bit [1:0] bpix, input bit sv, input bit [1:0] spix,
                           input bit spal, input bit sprio, input bit stall, input int ovr);
        bit exp_pop, exp_spop;
        bit [1:0] bi, sh;
        bit [7:0] pal;
        tclk = 1'b1;
        bg_valid = bgv;
        bg_pixel = bpix;
        sprite_valid = sv;
        sprite_pixel = spix;
        sprite_palette = spal;
        sprite_priority = sprio;
        sprite_stall = stall;
        exp_pop = bgv && !stall && (m_state == 1 || m_state == 2);
        exp_spop = exp_pop && sv && (m_state == 2);
        #1;
        check("bg_rd", bg_rd, exp_pop);
        check("sprite_rd", sprite_rd, exp_spop);
        if (exp_pop) begin
            if (m_state == 1) begin
                m_disc--;
                if (m_disc == 0) m_state = 2;
            end else begin
                bi = bg_ena ? bpix : 2'd0;
                if (sprite_ena && sv && spix != 0 && (!sprio || bi == 0)) begin
                    pal = spal ? obp1 : obp0;
                    sh = 2'(pal >> (2 * spix));
                end else begin
                    sh = 2'(bgp >> (2 * bi));
                end
                if (ovr >= 0) sh = 2'(ovr);
                sb.push_back({(m_x == X_MAX - 1), 8'(m_x), sh});
                if (m_x == X_MAX - 1) m_state = 3;
                m_x++;
            end
        end
        @(posedge clk);
        #1;
        tclk = 1'b0;
        #1;
        check("idle_rd", bg_rd, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_pixel();
        if ($urandom_range(15) == 0) bgp = 8'($urandom);
        if ($urandom_range(15) == 0) obp0 = 8'($urandom);
        t_cycle($urandom_range(7) != 0, 2'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'b0, -1);
    endtask

    task automatic start_line(input bit [7:0] s);
        line_start = 1'b1;
        scx = s;
        tclk = 1'b1;
        bg_valid = 1'b1;
        sprite_stall = 1'b0;
        #1;
        check("line_start_no_pop", bg_rd, 0);
        @(posedge clk);
        #1;
        line_start = 1'b0;
        tclk = 1'b0;
        m_disc = int'(s[2:0]);
        m_x = 0;
        m_state = (m_disc != 0) ? 1 : 2;
        pix_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc;
        rst_n = 1'b0;
        tclk = 0; line_start = 0; scx = 0; bg_ena = 1; sprite_ena = 1;
        bgp = 8'hE4; obp0 = 8'hD2; obp1 = 8'h1B;
        bg_pixel = 0; bg_valid = 1; sprite_pixel = 0; sprite_valid = 0;
        sprite_palette = 0; sprite_priority = 0; sprite_stall = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_shade", shade, 0);
        check("rst_x", x_out, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_done", line_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) t_cycle(1, 1, 0, 0, 0, 0, 0, -1);

        // Fine scroll of 3 then indices 1,2,3,0,1,...
        start_line(8'h0B);
        for (int k = 0; k < 8; k++) begin
            t_cycle(1, 2'((k + 1) % 4), 0, 0, 0, 0, 0, (k == 3) ? 0 : -1);
            if (k == 2) check("discard_silent", pix_cnt, 0);
        end

        // Priority cases against fixed shades.
        t_cycle(1, 2, 1, 1, 1, 0, 0, 2);
        t_cycle(1, 2, 1, 1, 1, 1, 0, 2);
        t_cycle(1, 0, 1, 1, 1, 1, 0, 2);
        t_cycle(1, 2, 1, 0, 1, 0, 0, 2);
        bg_ena = 0;
        t_cycle(1, 3, 0, 0, 0, 0, 0, 0);
        bg_ena = 1;
        t_cycle(1, 1, 1, 3, 0, 0, 0, 3);

        // Stall then empty FIFO mid-line.
        repeat (5) rnd_pixel();
        pc = pix_cnt;
        repeat (6) t_cycle(1, 2, 1, 2, 0, 0, 1, -1);
        repeat (2) t_cycle(0, 3, 0, 0, 0, 0, 0, -1);
        check("stall_quiet", pix_cnt, pc);
        repeat (4) rnd_pixel();
        while (m_state == 2) rnd_pixel();

        // Full line without scroll.
        start_line(8'h00);
        while (m_state == 2) t_cycle(1, 2'($urandom), 0, 0, 0, 0, 0, -1);
        check("line_pixel_count", pix_cnt, X_MAX);
        check("line_last_x", last_x, X_MAX - 1);
        repeat (4) t_cycle(1, 1, 1, 1, 0, 0, 0, -1);
        check("done_quiet", pix_cnt, X_MAX);

        // Restart mid-line at X=77 with a new scroll.
        start_line(8'h02);
        while (m_x < 77) rnd_pixel();
        start_line(8'h05);
        repeat (12) rnd_pixel();

        // Asynchronous reset mid-line at X=40.
        while (m_x < 40) rnd_pixel();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_shade", shade, 0);
        check("midrst_x", x_out, 0);
        check("midrst_valid", pixel_valid, 0);
        check("midrst_sb_empty", sb.size(), 0);
        m_state = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) t_cycle(1, 2, 1, 1, 0, 0, 0, -1);

        repeat (3) @(posedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_mixer.md
Name: pixel_mixer

Overview:
- Downstream stage of the background and sprite pixel FIFOs.
- Once per T-cycle it pops one background pixel and, when present, the matching sprite pixel. It drops the first SCX[2:0] background pixels of each line.
- It resolves sprite/background priority, maps the winning 2-bit colour index through BGP/OBP0/OBP1, and emits a registered 2-bit shade plus X coordinate to the LCD writer.
- It tracks the horizontal pixel count and flags end of the drawing phase to the PPU mode controller.

Parameters:
- X_MAX, 160, visible pixels per line; the line ends after X_MAX drawn pixels.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- tclk_in  input  1  T-cycle enable, one clk_in cycle wide
- line_start_in  input  1  pulse: begin new line (mode 3 entry)
- SCX_in  input  8  scroll X; only [2:0] used, latched at line_start_in
- bg_ena_in  input  1  LCDC.0 background enable
- sprite_ena_in  input  1  LCDC.1 sprite enable
- BGP_in  input  8  background palette
- OBP0_in  input  8  sprite palette 0
- OBP1_in  input  8  sprite palette 1
- bg_pixel_in  input  2  background FIFO head colour index
- bg_valid_in  input  1  background FIFO non-empty
- bg_rd_out  output  1  pop background FIFO (combinational)
- sprite_pixel_in  input  2  sprite FIFO head colour index
- sprite_valid_in  input  1  sprite pixel present at head
- sprite_palette_in  input  1  0=OBP0, 1=OBP1
- sprite_priority_in  input  1  1 = background colours 1-3 win over sprite
- sprite_stall_in  input  1  sprite fetch in progress; freeze popping
- sprite_rd_out  output  1  pop sprite FIFO (combinational)
- shade_out  output  2  final shade
- X_out  output  $clog2(X_MAX)  X of pixel on shade_out
- pixel_valid_out  output  1  one clk_in pulse per drawn pixel
- line_done_out  output  1  one clk_in pulse after pixel X_MAX-1

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. shade_out=0, X_out=0, pixel_valid_out=0, line_done_out=0. Discard counter=0. Reset mid-line abandons the line immediately.
- States: IDLE, DISCARD, DRAW, DONE.
- line_start_in (any state, highest priority):
  - Latch disc=SCX_in[2:0] and clear X.
  - Go to DISCARD if disc!=0, else DRAW.
  - No pop occurs in that cycle.
- pop = tclk_in && bg_valid_in && !sprite_stall_in && state in {DISCARD, DRAW}.
  - bg_rd_out = pop.
  - sprite_rd_out = pop && sprite_valid_in && state==DRAW.
  - Sprite FIFO is never popped in DISCARD.
- DISCARD:
  - Each pop decrements disc; no output.
  - The pop that takes disc to 0 moves to DRAW.
- DRAW, per pop:
  - bi = bg_ena_in ? bg_pixel_in : 0.
  - Sprite wins iff sprite_ena_in && sprite_valid_in && sprite_pixel_in!=0 && (!sprite_priority_in || bi==0).
  - Winner index i selects palette bits [2i+1:2i] of OBPx (sprite) or BGP (background).
  - Next clk_in cycle:
    - shade_out = mapped shade.
    - X_out = current X.
    - pixel_valid_out = 1 for exactly one cycle.
    - X increments.
  - Latency: pop at edge N gives valid output after edge N+1. shade_out and X_out hold between pulses.
- Line end:
  - The pop with X==X_MAX-1 moves to DONE.
  - line_done_out pulses in the same cycle as that pixel's pixel_valid_out.
  - DONE and IDLE ignore tclk_in and pop nothing until line_start_in.
- Stall: sprite_stall_in high holds all state and counters, with no pops. Output resumes on the first T-cycle after deassertion with bg_valid_in.
- Empty: bg_valid_in=0 on a T-cycle means no pop and no output. The pixel is not skipped.
- Palettes and enables are sampled at pop time; mid-line writes affect subsequent pixels only.

Test Plan:
- Reset value check: hold rst_in low, toggle clk_in → all outputs 0. Release reset with bg_valid_in=1 and no line_start_in → no bg_rd_out.
- Discard: SCX_in=0x0B, line_start_in, bg indices 1,2,3,0,1,… each T-cycle → first 3 pops silent. First pixel_valid_out carries index 0 through BGP=0xE4 → shade 0, X_out=0.
- Priority: BGP=0xE4, OBP1=0x1B, bg=2, sprite=1, palette=1.
  - priority=0 → shade 2 (OBP1[3:2]).
  - priority=1 → shade 2 (BGP[5:4]).
  - bg=0, priority=1 → shade 2 (sprite wins).
  - sprite=0 → background shade.
  - bg_ena_in=0 with bg=3, no sprite → shade BGP[1:0].
- Stall/empty: assert sprite_stall_in for 6 T-cycles mid-line, then drop bg_valid_in for 2 T-cycles → no pops, no outputs, X frozen. Next pixel continues at the following X with no gaps or duplicates.
- Line end: SCX=0, 160 consecutive valid pops → pixel_valid_out count 160, last X_out=159. line_done_out coincides with the last pixel. Further T-cycles produce nothing until the next line_start_in.
- Reset/restart mid-line:
  - line_start_in at X=77 → X restarts at 0 with the new SCX discard.
  - rst_in low at X=40 → outputs 0 immediately, state IDLE.
